// File: rtl/instruction_encoder_pkg.sv
// Shared RV32I instruction constants: encoding-format selector and major opcodes.
package instruction_encoder_pkg;

    // One-hot format selector; all-zero selects R-type.
    typedef logic [4:0] EncodingType;

    localparam int ENC_I_BIT = 0;
    localparam int ENC_S_BIT = 1;
    localparam int ENC_B_BIT = 2;
    localparam int ENC_U_BIT = 3;
    localparam int ENC_J_BIT = 4;

    localparam EncodingType ENC_R = 5'b00000;
    localparam EncodingType ENC_I = 5'b00001;
    localparam EncodingType ENC_S = 5'b00010;
    localparam EncodingType ENC_B = 5'b00100;
    localparam EncodingType ENC_U = 5'b01000;
    localparam EncodingType ENC_J = 5'b10000;

    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_SYSTEM = 7'h73;

endpackage

// File: rtl/instruction_encoder_imm_pack.sv
// Scatters an immediate into its RV32I bit positions for the selected format.
// With INSTRUCTION_ENCODER_RANGE_CHECK_EN defined it also flags out-of-range immediates.
module imm_pack
    import instruction_encoder_pkg::*;
(
    input  EncodingType  en,
    input  logic [31:0]  imm,
`ifdef INSTRUCTION_ENCODER_RANGE_CHECK_EN
    output logic         err,
`endif
    output logic [31:0]  imm_bits
);

    // Format priority I > S > B > U > J if more than one selector bit is set.
    always_comb begin
        imm_bits = '0;
        if (en[ENC_I_BIT]) begin
            imm_bits[31:20] = imm[11:0];
        end else if (en[ENC_S_BIT]) begin
            imm_bits[31:25] = imm[11:5];
            imm_bits[11:7]  = imm[4:0];
        end else if (en[ENC_B_BIT]) begin
            imm_bits[31]    = imm[12];
            imm_bits[30:25] = imm[10:5];
            imm_bits[11:8]  = imm[4:1];
            imm_bits[7]     = imm[11];
        end else if (en[ENC_U_BIT]) begin
            imm_bits[31:12] = imm[31:12];
        end else if (en[ENC_J_BIT]) begin
            imm_bits[31]    = imm[20];
            imm_bits[30:21] = imm[10:1];
            imm_bits[20]    = imm[11];
            imm_bits[19:12] = imm[19:12];
        end
    end

`ifdef INSTRUCTION_ENCODER_RANGE_CHECK_EN
    logic fits12;
    logic fits13;
    logic fits21;

    // A value fits an N-bit signed field when every bit above N-2 equals the sign.
    always_comb begin
        fits12 = (imm[31:11] == '0) || (imm[31:11] == '1);
        fits13 = (imm[31:12] == '0) || (imm[31:12] == '1);
        fits21 = (imm[31:20] == '0) || (imm[31:20] == '1);
        err    = 1'b0;
        if (en[ENC_I_BIT] || en[ENC_S_BIT]) begin
            err = !fits12;
        end else if (en[ENC_B_BIT]) begin
            err = !fits13 || imm[0];
        end else if (en[ENC_U_BIT]) begin
            err = (imm[11:0] != 12'h000);
        end else if (en[ENC_J_BIT]) begin
            err = !fits21 || imm[0];
        end
    end
`endif

endmodule

// File: rtl/instruction_encoder.sv
// Packs decoded RV32I fields into an instruction word behind a one-deep valid/ready stage.
// Optional immediate range checking is enabled by INSTRUCTION_ENCODER_RANGE_CHECK_EN.
module instruction_encoder
    import instruction_encoder_pkg::*;
#(
    parameter int                ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  EncodingType       en,
    input  logic [6:0]        opcode,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [31:0]       imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_inst,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err,
    output logic [7:0]        err_count
);

    logic [31:0] imm_bits;
    logic [31:0] word;
    logic        in_xfer;
    logic        out_xfer;

`ifdef INSTRUCTION_ENCODER_RANGE_CHECK_EN
    logic imm_err;

    imm_pack u_imm_pack (
        .en       (en),
        .imm      (imm),
        .err      (imm_err),
        .imm_bits (imm_bits)
    );
`else
    imm_pack u_imm_pack (
        .en       (en),
        .imm      (imm),
        .imm_bits (imm_bits)
    );
`endif

    assign in_ready = !flush && (!out_valid || out_ready);
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    // Register fields overlay the immediate; the format priority matches imm_pack.
    always_comb begin
        word      = imm_bits;
        word[6:0] = opcode;
        if (en == ENC_R) begin
            word = {funct7, rs2, rs1, funct3, rd, opcode};
        end else if (en[ENC_I_BIT]) begin
            word[19:15] = rs1;
            word[14:12] = funct3;
            word[11:7]  = rd;
        end else if (en[ENC_S_BIT] || en[ENC_B_BIT]) begin
            word[24:20] = rs2;
            word[19:15] = rs1;
            word[14:12] = funct3;
        end else begin
            word[11:7]  = rd;
        end
    end

    // The address belongs to the held word, so it only moves when that word leaves.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_inst  <= '0;
            out_addr  <= BASE_ADDR;
        end else if (flush) begin
            out_valid <= 1'b0;
            out_addr  <= BASE_ADDR;
        end else begin
            if (out_xfer) begin
                out_addr <= out_addr + ADDR_W'(4);
            end
            if (in_xfer) begin
                out_valid <= 1'b1;
                out_inst  <= word;
            end else if (out_xfer) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef INSTRUCTION_ENCODER_RANGE_CHECK_EN
    // The count reflects errored words actually taken by the sink.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_err   <= 1'b0;
            err_count <= '0;
        end else if (flush) begin
            out_err   <= 1'b0;
            err_count <= '0;
        end else begin
            if (out_xfer && out_err && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
            if (in_xfer) begin
                out_err <= imm_err;
            end
        end
    end
`else
    assign out_err   = 1'b0;
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed scoreboard bench for instruction_encoder: a 16-bit-address and a 4-bit-address
// instance share the same stimulus; expected words are queued on acceptance.
module tb_instruction_encoder;
    import instruction_encoder_pkg::*;

`ifdef INSTRUCTION_ENCODER_RANGE_CHECK_EN
    localparam logic RC = 1'b1;
`else
    localparam logic RC = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] inst;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    EncodingType en;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        out_ready;

    logic        a_in_ready, w_in_ready;
    logic        a_valid, w_valid;
    logic [31:0] a_inst, w_inst;
    logic [15:0] a_addr;
    logic [3:0]  w_addr;
    logic        a_err, w_err;
    logic [7:0]  a_cnt, w_cnt;

    exp_t        sb[$];
    exp_t        pending;
    logic [15:0] m_addr;
    logic [7:0]  m_errcnt;
    int          checks   = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    instruction_encoder dut_a (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready), .en(en),
        .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .out_valid(a_valid), .out_ready(out_ready), .out_inst(a_inst),
        .out_addr(a_addr), .out_err(a_err), .err_count(a_cnt)
    );

    instruction_encoder #(.ADDR_W(4), .BASE_ADDR(4'd0)) dut_w (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(w_in_ready), .en(en),
        .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .out_valid(w_valid), .out_ready(out_ready), .out_inst(w_inst),
        .out_addr(w_addr), .out_err(w_err), .err_count(w_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input EncodingType e, input logic [6:0] op,
                                 input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] d,
                                 input logic [4:0] s1, input logic [4:0] s2, input logic [31:0] im,
                                 input logic [31:0] xi, input logic xe);
        in_valid = v;
        en       = e;
        opcode   = op;
        funct3   = f3;
        funct7   = f7;
        rd       = d;
        rs1      = s1;
        rs2      = s2;
        imm      = im;
        pending  = '{inst: xi, err: xe};
    endtask

    task automatic checkOutput();
        logic exp_ready;
        exp_ready = !flush && ((sb.size() == 0) || out_ready);
        check("in_ready_a", 32'(a_in_ready), 32'(exp_ready));
        check("in_ready_w", 32'(w_in_ready), 32'(exp_ready));
        check("out_valid_a", 32'(a_valid), 32'(sb.size() != 0));
        check("out_valid_w", 32'(w_valid), 32'(sb.size() != 0));
        check("out_addr_a", 32'(a_addr), 32'(m_addr));
        check("out_addr_w", 32'(w_addr), 32'(m_addr[3:0]));
        check("err_count_a", 32'(a_cnt), 32'(m_errcnt));
        check("err_count_w", 32'(w_cnt), 32'(m_errcnt));
        if (sb.size() != 0) begin
            check("out_inst_a", a_inst, sb[0].inst);
            check("out_inst_w", w_inst, sb[0].inst);
            check("out_err_a", 32'(a_err), 32'(sb[0].err));
            check("out_err_w", 32'(w_err), 32'(sb[0].err));
        end
    endtask

    task automatic checkReset();
        check("rst_valid_a", 32'(a_valid), 32'd0);
        check("rst_valid_w", 32'(w_valid), 32'd0);
        check("rst_inst_a", a_inst, 32'd0);
        check("rst_inst_w", w_inst, 32'd0);
        check("rst_addr_a", 32'(a_addr), 32'd0);
        check("rst_addr_w", 32'(w_addr), 32'd0);
        check("rst_err_a", 32'(a_err), 32'd0);
        check("rst_err_w", 32'(w_err), 32'd0);
        check("rst_cnt_a", 32'(a_cnt), 32'd0);
        check("rst_cnt_w", 32'(w_cnt), 32'd0);
    endtask

    // One clock: compare at the falling edge, then advance the model at the rising edge.
    task automatic tick();
        logic in_x;
        logic out_x;
        @(negedge clk);
        checkOutput();
        in_x  = in_valid && !flush && ((sb.size() == 0) || out_ready);
        out_x = (sb.size() != 0) && out_ready;
        @(posedge clk);
        if (flush) begin
            sb.delete();
            m_addr   = 16'h0000;
            m_errcnt = 8'h00;
        end else begin
            if (out_x) begin
                if (sb[0].err && (m_errcnt != 8'hFF)) m_errcnt = m_errcnt + 8'd1;
                void'(sb.pop_front());
                m_addr = m_addr + 16'd4;
            end
            if (in_x) sb.push_back(pending);
        end
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    initial begin
        reset_n   = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b1;
        m_addr    = 16'h0000;
        m_errcnt  = 8'h00;
        applyStimulus(1'b0, ENC_R, 7'h00, 3'h0, 7'h00, 5'h00, 5'h00, 5'h00, 32'h0, 32'h0, 1'b0);
        #2 reset_n = 1'b0;
        #2 checkReset();
        @(posedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // addi x1,x0,5 with junk in unused fields; visible one cycle after acceptance
        applyStimulus(1'b1, ENC_I, OPC_OP_IMM, 3'h0, 7'h7F, 5'd1, 5'd0, 5'd31, 32'd5, 32'h00500093, 1'b0);
        tick();
        idle(); tick();
        tick();

        flush = 1'b1; tick(); flush = 1'b0;

        // Back-to-back stream; the 4-bit instance wraps on the fifth word
        applyStimulus(1'b1, ENC_S, OPC_STORE, 3'h2, 7'h55, 5'h1F, 5'd1, 5'd2, 32'd8, 32'h0020A423, 1'b0);
        tick();
        applyStimulus(1'b1, ENC_B, OPC_BRANCH, 3'h0, 7'h2A, 5'h15, 5'd0, 5'd0, -32'sd4, 32'hFE000EE3, 1'b0);
        tick();
        applyStimulus(1'b1, ENC_U, OPC_LUI, 3'h7, 7'h7F, 5'd5, 5'd31, 5'd31, 32'h12345000, 32'h123452B7, 1'b0);
        tick();
        applyStimulus(1'b1, ENC_J, OPC_JAL, 3'h5, 7'h11, 5'd1, 5'd9, 5'd17, 32'd2048, 32'h001000EF, 1'b0);
        tick();
        applyStimulus(1'b1, ENC_R, OPC_OP, 3'h0, 7'h20, 5'd3, 5'd1, 5'd2, 32'hFFFFFFFF, 32'h402081B3, 1'b0);
        tick();
        idle(); tick();
        tick();

        // Backpressure: word held for three cycles, then the next follows without a bubble
        applyStimulus(1'b1, ENC_I, OPC_OP_IMM, 3'h0, 7'h00, 5'd2, 5'd0, 5'd0, -32'sd1, 32'hFFF00113, 1'b0);
        tick();
        out_ready = 1'b0;
        applyStimulus(1'b1, ENC_I, OPC_OP_IMM, 3'h7, 7'h00, 5'd3, 5'd3, 5'd0, 32'h0F, 32'h00F1F193, 1'b0);
        tick();
        tick();
        tick();
        out_ready = 1'b1;
        tick();
        idle(); tick();
        tick();

        // Out-of-range immediates encode truncated bits; flagged only with the check built in
        applyStimulus(1'b1, ENC_I, OPC_OP_IMM, 3'h0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd2048, 32'h80000093, RC);
        tick();
        applyStimulus(1'b1, ENC_B, OPC_BRANCH, 3'h0, 7'h00, 5'd0, 5'd0, 5'd0, 32'd3, 32'h00000163, RC);
        tick();
        idle(); tick();
        tick();

        // Flush while holding a word with a new input presented
        applyStimulus(1'b1, ENC_U, OPC_LUI, 3'h0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h12345000, 32'h123452B7, 1'b0);
        tick();
        out_ready = 1'b0;
        idle(); tick();
        flush = 1'b1;
        applyStimulus(1'b1, ENC_J, OPC_JAL, 3'h0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd2048, 32'h001000EF, 1'b0);
        tick();
        flush = 1'b0;
        idle(); tick();
        out_ready = 1'b1;
        tick();

        // Asynchronous reset in the middle of a stream
        applyStimulus(1'b1, ENC_S, OPC_STORE, 3'h2, 7'h00, 5'd0, 5'd1, 5'd2, 32'd8, 32'h0020A423, 1'b0);
        tick();
        applyStimulus(1'b1, ENC_B, OPC_BRANCH, 3'h0, 7'h00, 5'd0, 5'd0, 5'd0, -32'sd4, 32'hFE000EE3, 1'b0);
        tick();
        idle();
        #2 reset_n = 1'b0;
        #1 checkReset();
        sb.delete();
        m_addr   = 16'h0000;
        m_errcnt = 8'h00;
        @(posedge clk);
        #1 reset_n = 1'b1;
        applyStimulus(1'b1, ENC_I, OPC_OP_IMM, 3'h0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5, 32'h00500093, 1'b0);
        tick();
        idle(); tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
